// File: rtl/circle_raster_pkg.sv
// circle_raster_pkg
//   Shared types and constants for the circle rasteriser.
//   - state_e     : FSM state encoding
//   - MODE_*      : command mode (outline points / filled spans)
//   - LAST_IDX_*  : last candidate index per mode
//   - work_width  : signed working width for x, y, d and candidate coordinates
package circle_raster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic       MODE_OUTLINE     = 1'b0;
  localparam logic       MODE_FILL        = 1'b1;
  localparam logic [2:0] LAST_IDX_OUTLINE = 3'd7;
  localparam logic [2:0] LAST_IDX_FILL    = 3'd3;

  // Two extra bits: one for the sign, one so x0 + r never overflows.
  localparam int WORK_PAD = 2;

  function automatic int work_width(input int coord_w);
    return coord_w + WORK_PAD;
  endfunction

endpackage

// File: rtl/circle_raster_gen_if.sv
// circle_raster_gen_if
//   Command and beat handshake bundle for circle_raster_gen.
//   Command side : x0_in, y0_in, r_in, color_in, fill_in, in_rts -> ; <- in_rtr
//   Beat side    : out_rts, out_xs, out_xe, out_y, out_color, done -> ; <- out_rtr
//   master = command decoder / framebuffer arbiter side, slave = rasteriser.
interface circle_raster_gen_if #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12
);

  logic [COORD_W-1:0] x0_in;
  logic [COORD_W-1:0] y0_in;
  logic [COORD_W-1:0] r_in;
  logic [COLOR_W-1:0] color_in;
  logic               fill_in;
  logic               in_rts;
  logic               in_rtr;

  logic               out_rts;
  logic               out_rtr;
  logic [COORD_W-1:0] out_xs;
  logic [COORD_W-1:0] out_xe;
  logic [COORD_W-1:0] out_y;
  logic [COLOR_W-1:0] out_color;
  logic               done;

  modport master (
    output x0_in, y0_in, r_in, color_in, fill_in, in_rts, out_rtr,
    input  in_rtr, out_rts, out_xs, out_xe, out_y, out_color, done
  );

  modport slave (
    input  x0_in, y0_in, r_in, color_in, fill_in, in_rts, out_rtr,
    output in_rtr, out_rts, out_xs, out_xe, out_y, out_color, done
  );

endinterface

// File: rtl/circle_octant_sel.sv
// circle_octant_sel
//   Combinational candidate generator: maps the centre, the current midpoint
//   offsets (x, y), the candidate index and the mode to one output beat.
//   Ports: x0_i/y0_i centre, x_i/y_i signed offsets, idx_i candidate index,
//          mode_i outline/fill, xs_o/xe_o/y_o beat coordinates, valid_o beat
//          is to be emitted.
//   CIRCLE_CLIP_EN: when defined, off-screen candidates are dropped and fill
//   spans are clamped to the screen (SCREEN_W/SCREEN_H exist only then).
//   Otherwise every candidate is valid and coordinates wrap modulo 2^COORD_W.
module circle_octant_sel
  import circle_raster_pkg::*;
#(
  parameter int COORD_W = 10
`ifdef CIRCLE_CLIP_EN
 ,parameter int SCREEN_W = 640
 ,parameter int SCREEN_H = 480
`endif
) (
  input  logic [COORD_W-1:0]                   x0_i,
  input  logic [COORD_W-1:0]                   y0_i,
  input  logic signed [work_width(COORD_W)-1:0] x_i,
  input  logic signed [work_width(COORD_W)-1:0] y_i,
  input  logic [2:0]                           idx_i,
  input  logic                                 mode_i,
  output logic [COORD_W-1:0]                   xs_o,
  output logic [COORD_W-1:0]                   xe_o,
  output logic [COORD_W-1:0]                   y_o,
  output logic                                 valid_o
);

  localparam int WORK_W = work_width(COORD_W);

  logic signed [WORK_W-1:0] cx0, cy0;
  logic signed [WORK_W-1:0] axs, axe, ay;

  assign cx0 = signed'({{(WORK_W-COORD_W){1'b0}}, x0_i});
  assign cy0 = signed'({{(WORK_W-COORD_W){1'b0}}, y0_i});

  always_comb begin
    axs = cx0;
    axe = cx0;
    ay  = cy0;
    if (mode_i == MODE_FILL) begin
      case (idx_i[1:0])
        2'd0: begin axs = cx0 - x_i; axe = cx0 + x_i; ay = cy0 + y_i; end
        2'd1: begin axs = cx0 - x_i; axe = cx0 + x_i; ay = cy0 - y_i; end
        2'd2: begin axs = cx0 - y_i; axe = cx0 + y_i; ay = cy0 + x_i; end
        2'd3: begin axs = cx0 - y_i; axe = cx0 + y_i; ay = cy0 - x_i; end
      endcase
    end else begin
      case (idx_i)
        3'd0: begin axs = cx0 + x_i; ay = cy0 + y_i; end
        3'd1: begin axs = cx0 + y_i; ay = cy0 + x_i; end
        3'd2: begin axs = cx0 - y_i; ay = cy0 + x_i; end
        3'd3: begin axs = cx0 - x_i; ay = cy0 + y_i; end
        3'd4: begin axs = cx0 - x_i; ay = cy0 - y_i; end
        3'd5: begin axs = cx0 - y_i; ay = cy0 - x_i; end
        3'd6: begin axs = cx0 + y_i; ay = cy0 - x_i; end
        3'd7: begin axs = cx0 + x_i; ay = cy0 - y_i; end
      endcase
      axe = axs;
    end
  end

`ifdef CIRCLE_CLIP_EN
  localparam logic signed [WORK_W-1:0] MAX_X = WORK_W'(SCREEN_W - 1);
  localparam logic signed [WORK_W-1:0] MAX_Y = WORK_W'(SCREEN_H - 1);

  logic signed [WORK_W-1:0] cxs, cxe;
  logic                     unused_hi;

  // A point is a span with xs == xe, so one test covers both modes.
  always_comb begin
    cxs     = axs;
    cxe     = axe;
    valid_o = !ay[WORK_W-1] && (ay <= MAX_Y) && !axe[WORK_W-1] && (axs <= MAX_X);
    if (axs[WORK_W-1]) cxs = '0;
    if (axe > MAX_X)   cxe = MAX_X;
  end

  assign xs_o      = cxs[COORD_W-1:0];
  assign xe_o      = cxe[COORD_W-1:0];
  assign y_o       = ay[COORD_W-1:0];
  assign unused_hi = ^{cxs[WORK_W-1:COORD_W], cxe[WORK_W-1:COORD_W]};
`else
  logic unused_hi;

  assign valid_o   = 1'b1;
  assign xs_o      = axs[COORD_W-1:0];
  assign xe_o      = axe[COORD_W-1:0];
  assign y_o       = ay[COORD_W-1:0];
  assign unused_hi = ^{axs[WORK_W-1:COORD_W], axe[WORK_W-1:COORD_W], ay[WORK_W-1:COORD_W]};
`endif

endmodule

// File: rtl/circle_raster_gen.sv
// circle_raster_gen
//   Midpoint circle rasteriser. Takes one command (centre, radius, colour,
//   mode) and streams one pixel (outline) or one horizontal span (fill) per
//   beat, then pulses done.
//   Ports: clk, rst_ (async, active low), bus (circle_raster_gen_if.slave)
//   carrying the command handshake (in_rts/in_rtr) and the beat handshake
//   (out_rts/out_rtr) with out_xs/out_xe/out_y/out_color, plus done.
//   CIRCLE_CLIP_EN: enables screen clipping (adds SCREEN_W/SCREEN_H).
//
//   state | meaning
//   IDLE  | waiting for a command, in_rtr = 1
//   EMIT  | presenting candidates idx 0..last for the current (x, y)
//   STEP  | one bubble cycle advancing the midpoint (x, y, d)
//   DONE  | one-cycle done pulse, then back to IDLE
module circle_raster_gen
  import circle_raster_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12
`ifdef CIRCLE_CLIP_EN
 ,parameter int SCREEN_W = 640
 ,parameter int SCREEN_H = 480
`endif
) (
  input logic                clk,
  input logic                rst_,
  circle_raster_gen_if.slave bus
);

  localparam int WORK_W = work_width(COORD_W);
  typedef logic signed [WORK_W-1:0] work_t;
  localparam work_t W_ONE = work_t'(1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               mode_q, mode_d;
  work_t              x_q, x_d, y_q, y_d, d_q, d_d;
  logic [2:0]         idx_q, idx_d;

  logic               in_rtr_q, in_rtr_d;
  logic               out_rts_q, out_rts_d;
  logic               done_q, done_d;
  logic [COORD_W-1:0] out_xs_q, out_xs_d, out_xe_q, out_xe_d, out_y_q, out_y_d;
  logic [COLOR_W-1:0] out_color_q, out_color_d;

  logic               in_xfc, out_xfc;
  logic [2:0]         last_idx;
  work_t              r_ext, y_inc, x_dec;
  logic [COORD_W-1:0] cand_xs, cand_xe, cand_y;
  logic               cand_valid;

  assign in_xfc   = bus.in_rts & in_rtr_q;
  assign out_xfc  = out_rts_q & bus.out_rtr;
  assign last_idx = (mode_q == MODE_FILL) ? LAST_IDX_FILL : LAST_IDX_OUTLINE;
  assign r_ext    = work_t'({{(WORK_W-COORD_W){1'b0}}, bus.r_in});
  assign y_inc    = y_q + W_ONE;
  assign x_dec    = x_q - W_ONE;

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    color_d = color_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_xfc) begin
          x0_d    = bus.x0_in;
          y0_d    = bus.y0_in;
          color_d = bus.color_in;
          mode_d  = bus.fill_in;
          x_d     = r_ext;
          y_d     = '0;
          d_d     = W_ONE - r_ext;
          idx_d   = '0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // A clipped candidate has out_rts low, so it is skipped in one cycle.
        if (out_xfc || !out_rts_q) begin
          if (idx_q == last_idx) state_d = ST_STEP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      ST_STEP: begin
        y_d = y_inc;
        if (d_q[WORK_W-1]) begin
          d_d = d_q + (y_inc <<< 1) + W_ONE;
        end else begin
          x_d = x_dec;
          d_d = d_q + ((y_inc - x_dec) <<< 1) + W_ONE;
        end
        idx_d   = '0;
        state_d = (x_d < y_d) ? ST_DONE : ST_EMIT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Candidate for the next cycle is built from the next-state registers so the
  // output fields are registered and the first beat follows in_xfc by one cycle.
  circle_octant_sel #(
    .COORD_W (COORD_W)
`ifdef CIRCLE_CLIP_EN
   ,.SCREEN_W(SCREEN_W)
   ,.SCREEN_H(SCREEN_H)
`endif
  ) u_sel (
    .x0_i    (x0_d),
    .y0_i    (y0_d),
    .x_i     (x_d),
    .y_i     (y_d),
    .idx_i   (idx_d),
    .mode_i  (mode_d),
    .xs_o    (cand_xs),
    .xe_o    (cand_xe),
    .y_o     (cand_y),
    .valid_o (cand_valid)
  );

  always_comb begin
    in_rtr_d    = (state_d == ST_IDLE);
    done_d      = (state_d == ST_DONE);
    out_rts_d   = (state_d == ST_EMIT) && cand_valid;
    out_xs_d    = out_xs_q;
    out_xe_d    = out_xe_q;
    out_y_d     = out_y_q;
    out_color_d = out_color_q;
    // While stalled every _d equals its _q, so the reload below is a hold.
    if (state_d == ST_EMIT) begin
      out_xs_d    = cand_xs;
      out_xe_d    = cand_xe;
      out_y_d     = cand_y;
      out_color_d = color_d;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      color_q     <= '0;
      mode_q      <= MODE_OUTLINE;
      x_q         <= '0;
      y_q         <= '0;
      d_q         <= '0;
      idx_q       <= '0;
      in_rtr_q    <= 1'b1;
      out_rts_q   <= 1'b0;
      done_q      <= 1'b0;
      out_xs_q    <= '0;
      out_xe_q    <= '0;
      out_y_q     <= '0;
      out_color_q <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      color_q     <= color_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      d_q         <= d_d;
      idx_q       <= idx_d;
      in_rtr_q    <= in_rtr_d;
      out_rts_q   <= out_rts_d;
      done_q      <= done_d;
      out_xs_q    <= out_xs_d;
      out_xe_q    <= out_xe_d;
      out_y_q     <= out_y_d;
      out_color_q <= out_color_d;
    end
  end

  assign bus.in_rtr    = in_rtr_q;
  assign bus.out_rts   = out_rts_q;
  assign bus.out_xs    = out_xs_q;
  assign bus.out_xe    = out_xe_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_color = out_color_q;
  assign bus.done      = done_q;

endmodule
